// File: rtl/cyq_univ_reg_if.sv
// Bus bundle for the universal register: controls and data in, contents and terminal count out.
// There is no handshake on this bus; every input is sampled on the rising clock edge.
interface cyq_univ_reg_if #(
  parameter int WIDTH = 8
);
  logic             sd;
  logic             ce;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sr_in;
  logic             sl_in;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_n;
  logic             tc;

  modport master (
    output sd, ce, mode, d, sr_in, sl_in,
    input  q, q_n, tc
  );

  modport slave (
    input  sd, ce, mode, d, sr_in, sl_in,
    output q, q_n, tc
  );
endinterface

// File: rtl/cyq_univ_reg.sv
// WIDTH-bit universal register: hold, shift, rotate, load, up/down count,
// with synchronous active-low reset (to RST_VAL) and preset (to all ones).
module cyq_univ_reg #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic           clk,
  input logic           rd,
  cyq_univ_reg_if.slave bus
);

  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_SHR  = 3'b001,
    M_SHL  = 3'b010,
    M_LOAD = 3'b011,
    M_ROR  = 3'b100,
    M_ROL  = 3'b101,
    M_INC  = 3'b110,
    M_DEC  = 3'b111
  } mode_e;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_next;
  logic             w_tc;

  // Mode operations only; ce low keeps the register untouched even if mode is X.
  always_comb begin
    w_next = r_q;
    if (bus.ce) begin
      case (mode_e'(bus.mode))
        M_HOLD:  w_next = r_q;
        M_SHR:   w_next = {bus.sr_in, r_q[WIDTH-1:1]};
        M_SHL:   w_next = {r_q[WIDTH-2:0], bus.sl_in};
        M_LOAD:  w_next = bus.d;
        M_ROR:   w_next = {r_q[0], r_q[WIDTH-1:1]};
        M_ROL:   w_next = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        M_INC:   w_next = r_q + WIDTH'(1);
        M_DEC:   w_next = r_q - WIDTH'(1);
        default: w_next = r_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rd) begin
      r_q <= RST_VAL;
    end else if (!bus.sd) begin
      r_q <= '1;
    end else begin
      r_q <= w_next;
    end
  end

  // tc ignores ce so a chain can gate the next stage with (ce & tc).
  always_comb begin
    w_tc = 1'b0;
    if (bus.mode == M_INC && r_q == {WIDTH{1'b1}}) begin
      w_tc = 1'b1;
    end else if (bus.mode == M_DEC && r_q == '0) begin
      w_tc = 1'b1;
    end
  end

  assign bus.q   = r_q;
  assign bus.q_n = ~r_q;
  assign bus.tc  = w_tc;

endmodule

// File: tb/tb_cyq_univ_reg.sv
// Self-checking bench for cyq_univ_reg: directed scenarios, randomized ops against
// an arithmetic reference model, and a two-stage cascaded counter.
module tb_cyq_univ_reg;

  logic clk;
  logic rd;
  logic c_rd;
  int   checks;
  int   errors;

  cyq_univ_reg_if #(.WIDTH(8)) bus ();
  cyq_univ_reg_if #(.WIDTH(8)) lo_if ();
  cyq_univ_reg_if #(.WIDTH(8)) hi_if ();

  cyq_univ_reg #(.WIDTH(8), .RST_VAL(8'h5A)) dut (.clk(clk), .rd(rd), .bus(bus));
  cyq_univ_reg #(.WIDTH(8), .RST_VAL(8'h3C)) u_lo (.clk(clk), .rd(c_rd), .bus(lo_if));
  cyq_univ_reg #(.WIDTH(8), .RST_VAL(8'h00)) u_hi (.clk(clk), .rd(c_rd), .bus(hi_if));

  assign hi_if.ce = lo_if.ce & lo_if.tc;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: value after one edge, from plain arithmetic
  function automatic logic [7:0] model_next(input int q, input bit r, input bit s, input bit c,
                                            input int m, input int dv, input int sr, input int sl);
    int v;
    if (!r) return 8'h5A;
    if (!s) return 8'hFF;
    if (!c) return q[7:0];
    case (m)
      1:       v = q / 2 + sr * 128;
      2:       v = (q * 2 + sl) % 256;
      3:       v = dv;
      4:       v = q / 2 + (q % 2) * 128;
      5:       v = (q * 2) % 256 + q / 128;
      6:       v = (q + 1) % 256;
      7:       v = (q + 255) % 256;
      default: v = q;
    endcase
    return v[7:0];
  endfunction

  function automatic bit model_tc(input int q, input int m);
    return (m == 6 && q == 255) || (m == 7 && q == 0);
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit s, input bit c, input logic [2:0] m, input logic [7:0] dv,
                       input bit sr, input bit sl);
    bus.sd = s; bus.ce = c; bus.mode = m; bus.d = dv; bus.sr_in = sr; bus.sl_in = sl;
  endtask

  task automatic test_reset();
    rd = 1'b0;
    drive(1'b0, 1'b1, 3'b011, 8'hFF, 1'b1, 1'b1);
    tick();
    tick();
    checks++;
    if (bus.q !== 8'h5A) begin errors++; $display("FAIL reset_q got %h exp 5a", bus.q); end
    checks++;
    if (bus.q_n !== 8'hA5) begin errors++; $display("FAIL reset_qn got %h exp a5", bus.q_n); end
  endtask

  task automatic test_preset_load_hold();
    rd = 1'b1;
    drive(1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0);
    tick();
    checks++;
    if (bus.q !== 8'hFF) begin errors++; $display("FAIL preset_q got %h exp ff", bus.q); end
    drive(1'b1, 1'b1, 3'b011, 8'h3C, 1'b0, 1'b0);
    tick();
    checks++;
    if (bus.q !== 8'h3C) begin errors++; $display("FAIL load_q got %h exp 3c", bus.q); end
    drive(1'b1, 1'b0, 3'b110, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.q !== 8'h3C) begin errors++; $display("FAIL hold_ce0_q[%0d] got %h exp 3c", i, bus.q); end
    end
    checks++;
    if (bus.tc !== 1'b0) begin errors++; $display("FAIL hold_tc got %b exp 0", bus.tc); end
  endtask

  task automatic test_shift();
    drive(1'b1, 1'b1, 3'b011, 8'h81, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 3'b001, 8'h00, 1'b1, 1'b1);
    tick();
    checks++;
    if (bus.q !== 8'hC0) begin errors++; $display("FAIL shr_q got %h exp c0", bus.q); end
    drive(1'b1, 1'b1, 3'b010, 8'hFF, 1'b1, 1'b0);
    tick();
    checks++;
    if (bus.q !== 8'h80) begin errors++; $display("FAIL shl1_q got %h exp 80", bus.q); end
    tick();
    checks++;
    if (bus.q !== 8'h00) begin errors++; $display("FAIL shl2_q got %h exp 00", bus.q); end
  endtask

  task automatic test_rotate();
    drive(1'b1, 1'b1, 3'b011, 8'h81, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 3'b100, 8'h00, 1'b0, 1'b0);
    tick();
    checks++;
    if (bus.q !== 8'hC0) begin errors++; $display("FAIL ror_q got %h exp c0", bus.q); end
    drive(1'b1, 1'b1, 3'b101, 8'h00, 1'b0, 1'b0);
    tick();
    tick();
    checks++;
    if (bus.q !== 8'h03) begin errors++; $display("FAIL rol2_q got %h exp 03", bus.q); end
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (bus.q !== 8'h03) begin errors++; $display("FAIL rol_wrap_q got %h exp 03", bus.q); end
  endtask

  task automatic test_count_tc();
    drive(1'b1, 1'b1, 3'b011, 8'hFE, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 3'b110, 8'h00, 1'b0, 1'b0);
    #1;
    checks++;
    if (bus.tc !== 1'b0) begin errors++; $display("FAIL inc_tc_fe got %b exp 0", bus.tc); end
    tick();
    checks++;
    if (bus.q !== 8'hFF || bus.tc !== 1'b1) begin
      errors++; $display("FAIL inc_ff got q=%h tc=%b exp q=ff tc=1", bus.q, bus.tc);
    end
    tick();
    checks++;
    if (bus.q !== 8'h00 || bus.tc !== 1'b0) begin
      errors++; $display("FAIL inc_wrap got q=%h tc=%b exp q=00 tc=0", bus.q, bus.tc);
    end
    bus.mode = 3'b111;
    #1;
    checks++;
    if (bus.tc !== 1'b1) begin errors++; $display("FAIL dec_tc_00 got %b exp 1", bus.tc); end
    tick();
    checks++;
    if (bus.q !== 8'hFF) begin errors++; $display("FAIL dec_wrap got %h exp ff", bus.q); end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] m_q;
    bit r, s, c, sr, sl;
    int m, dv;
    rd = 1'b0;
    tick();
    rd = 1'b1;
    m_q = 8'h5A;
    for (int i = 0; i < 300; i++) begin
      r  = ($urandom_range(0, 19) != 0);
      s  = ($urandom_range(0, 14) != 0);
      c  = ($urandom_range(0, 3) != 0);
      m  = $urandom_range(0, 7);
      dv = $urandom_range(0, 255);
      sr = $urandom_range(0, 1);
      sl = $urandom_range(0, 1);
      // steer some passes onto the count boundaries
      if (i % 25 == 0) begin r = 1'b1; s = 1'b1; c = 1'b1; m = 3; dv = (i % 50 == 0) ? 255 : 0; end
      rd = r;
      drive(s, c, m[2:0], dv[7:0], sr, sl);
      #1;
      checks++;
      if (bus.tc !== model_tc(m_q, m)) begin
        errors++; $display("FAIL rand_tc[%0d] got %b exp %b", i, bus.tc, model_tc(m_q, m));
      end
      m_q = model_next(m_q, r, s, c, m, dv, sr, sl);
      exp_q.push_back(m_q);
      tick();
      checks++;
      if (bus.q !== exp_q[0] || bus.q_n !== ~exp_q[0]) begin
        errors++;
        $display("FAIL rand_q[%0d] got q=%h q_n=%h exp q=%h mode=%0d", i, bus.q, bus.q_n, exp_q[0], m);
      end
      void'(exp_q.pop_front());
    end
    rd = 1'b1;
  endtask

  task automatic test_cascade();
    int cnt;
    bit c;
    c_rd = 1'b0;
    lo_if.sd = 1'b1; lo_if.ce = 1'b1; lo_if.mode = 3'b000;
    hi_if.sd = 1'b1; hi_if.mode = 3'b000;
    tick();
    checks++;
    if ({hi_if.q, lo_if.q} !== 16'h003C) begin
      errors++; $display("FAIL casc_reset got %h exp 003c", {hi_if.q, lo_if.q});
    end
    c_rd = 1'b1;
    lo_if.sd = 1'b0;
    tick();
    lo_if.sd = 1'b1;
    lo_if.mode = 3'b110;
    hi_if.mode = 3'b110;
    #1;
    checks++;
    if ({hi_if.q, lo_if.q} !== 16'h00FF || lo_if.tc !== 1'b1) begin
      errors++; $display("FAIL casc_start got %h tc=%b exp 00ff tc=1", {hi_if.q, lo_if.q}, lo_if.tc);
    end
    tick();
    checks++;
    if ({hi_if.q, lo_if.q} !== 16'h0100) begin
      errors++; $display("FAIL casc_carry got %h exp 0100", {hi_if.q, lo_if.q});
    end
    cnt = 16'h0100;
    for (int i = 0; i < 600; i++) begin
      c = ($urandom_range(0, 4) != 0);
      lo_if.ce = c;
      tick();
      if (c) cnt = (cnt + 1) % 65536;
      checks++;
      if ({hi_if.q, lo_if.q} !== cnt[15:0]) begin
        errors++; $display("FAIL casc_count[%0d] got %h exp %h", i, {hi_if.q, lo_if.q}, cnt[15:0]);
      end
    end
    lo_if.ce = 1'b1;
    c_rd = 1'b0;
    tick();
    checks++;
    if ({hi_if.q, lo_if.q} !== 16'h003C) begin
      errors++; $display("FAIL casc_midreset got %h exp 003c", {hi_if.q, lo_if.q});
    end
    c_rd = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rd = 1'b0;
    c_rd = 1'b0;
    drive(1'b1, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0);
    lo_if.sd = 1'b1; lo_if.ce = 1'b0; lo_if.mode = 3'b000; lo_if.d = 8'h00;
    lo_if.sr_in = 1'b0; lo_if.sl_in = 1'b0;
    hi_if.sd = 1'b1; hi_if.mode = 3'b000; hi_if.d = 8'h00;
    hi_if.sr_in = 1'b0; hi_if.sl_in = 1'b0;
    #2;
    test_reset();
    test_preset_load_hold();
    test_shift();
    test_rotate();
    test_count_tc();
    test_random();
    test_cascade();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cyq_univ_reg.md
Name: cyq_univ_reg

Overview:
- Parametrised successor to the team's single-bit D flip-flop with set/clear: a WIDTH-bit universal register in the 74HC194 style, generalised with rotate and up/down count modes.
- Mode decoding is synchronous; preset and clear are synchronous and active-low.
- Used as the general-purpose storage/shift/count element in lab datapaths (serial-to-parallel conversion, LED chasers, small counters).
- Provides true and complemented outputs plus a terminal-count flag.

Parameters:
- WIDTH, 8, register width in bits; legal range 2..32.
- RST_VAL, 0, value loaded on reset; WIDTH bits wide.

Ports:
- clk  input  1  rising-edge clock.
- rd  input  1  synchronous reset, active-low; loads RST_VAL.
- sd  input  1  synchronous preset, active-low; loads all ones.
- ce  input  1  clock enable, active-high; gates mode operations only.
- mode  input  3  operation select (see Behaviour).
- d  input  WIDTH  parallel load data.
- sr_in  input  1  serial input for shift right; enters at MSB.
- sl_in  input  1  serial input for shift left; enters at LSB.
- q  output  WIDTH  register contents.
- q_n  output  WIDTH  bitwise complement of q, always.
- tc  output  1  terminal-count flag, combinational from q and mode.

Behaviour:
- All state changes occur on the rising edge of clk only. There is no asynchronous path.
- Priority at each edge is rd low > sd low > ce high with mode > hold.
- rd=0: q <= RST_VAL, regardless of sd, ce and mode.
- rd=1, sd=0: q <= all ones, regardless of ce and mode.
- rd=1, sd=1, ce=0: q holds.
- rd=1, sd=1, ce=1: mode decode as follows:
  - 000 hold: q <= q.
  - 001 shift right: q <= {sr_in, q[WIDTH-1:1]}.
  - 010 shift left: q <= {q[WIDTH-2:0], sl_in}.
  - 011 parallel load: q <= d.
  - 100 rotate right: q <= {q[0], q[WIDTH-1:1]}.
  - 101 rotate left: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - 110 increment: q <= q+1 modulo 2^WIDTH; all ones wraps to 0.
  - 111 decrement: q <= q-1 modulo 2^WIDTH; 0 wraps to all ones.
- Latency: every operation takes one cycle; the new q is visible after the edge. q_n tracks q with no extra register stage.
- tc is combinational:
  - 1 when mode=110 and q is all ones.
  - 1 when mode=111 and q is 0.
  - 0 otherwise.
  - tc is independent of ce, so it can be used for cascading: a downstream ce is driven by upstream (ce & tc).
- Serial inputs are sampled only in modes 001 and 010 and are ignored otherwise.
- d is sampled only in mode 011.
- Reset mid-operation: rd low on any edge overrides the operation in progress. No residual state exists (no internal counters beyond q).
- Power-up value before the first rd is undefined. The bench must assert rd for at least 1 edge.
- X on mode while ce=1 is not a legal input. The design's behaviour under it is unspecified, but it must not affect q when ce=0.

Test Plan:
- WIDTH=8, RST_VAL=8'h5A: hold rd=0 for 2 edges with sd=0, ce=1, mode=011, d=8'hFF -> q=8'h5A, q_n=8'hA5 (rd beats sd and load).
- rd=1, sd=0, ce=0 for 1 edge -> q=8'hFF. Then sd=1, ce=1, mode=011, d=8'h3C, 1 edge -> q=8'h3C. Then ce=0, mode=110 for 3 edges -> q stays 8'h3C.
- From q=8'h81: mode=001 with sr_in=1, 1 edge -> q=8'hC0. Then mode=010 with sl_in=0, 2 edges -> q=8'h00.
- From q=8'h81: mode=100, 1 edge -> q=8'hC0. Then mode=101, 2 edges -> q=8'h03. After 8 further rotate-left edges -> q=8'h03 (full wrap).
- From q=8'hFE: mode=110, ce=1. Check tc=0, then 1 edge -> q=8'hFF with tc=1; next edge -> q=8'h00 with tc=0. Switch to mode=111 -> tc=1 immediately; next edge -> q=8'hFF.
- Two instances cascaded (low-instance tc & ce drives high-instance ce), both in mode 110, from 16'h00FF -> one edge gives 16'h0100. Assert rd=0 mid-count -> both return to RST_VAL on that edge.
